// File: rtl/mul_pipe.sv
// Elastic integer multiply pipeline: valid/ready per stage with bubble collapsing,
// full 2*DATA_W product, ROB/PC/dst passthrough and per-slot hazard outputs.
// Optional signed-multiply support is enabled by defining MUL_PIPE_SIGNED_EN.
module mul_pipe #(
   parameter int DATA_W = 32,
   parameter int STAGES = 4,
   parameter int ROB_W  = 4,
   parameter int REG_W  = 5,
   parameter int PC_W   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_signed,
   input  logic [ROB_W-1:0]            in_rob,
   input  logic [PC_W-1:0]             in_pc,
   input  logic [REG_W-1:0]            in_dst,
   input  logic                        in_wr,
   input  logic [DATA_W-1:0]           in_a,
   input  logic [DATA_W-1:0]           in_b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ROB_W-1:0]            out_rob,
   output logic [PC_W-1:0]             out_pc,
   output logic [REG_W-1:0]            out_dst,
   output logic                        out_wr,
   output logic [DATA_W-1:0]           out_hi,
   output logic [DATA_W-1:0]           out_lo,
   output logic [STAGES:0]             haz_valid,
   output logic [(STAGES+1)*REG_W-1:0] haz_dst,
   output logic [$clog2(STAGES+1)-1:0] occ
);
   localparam int OCC_W = $clog2(STAGES+1);
   localparam int PW    = 2*DATA_W;

   // Sign- or zero-extend both operands to full width; the truncated product is exact.
   function automatic logic [PW-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic sgn);
      logic [PW-1:0] ea;
      logic [PW-1:0] eb;
      ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
      eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
      return ea * eb;
   endfunction

   logic [STAGES-1:0] v_r;
   logic [STAGES-1:0] wr_r;
   logic [ROB_W-1:0]  rob_r  [STAGES];
   logic [PC_W-1:0]   pc_r   [STAGES];
   logic [REG_W-1:0]  dst_r  [STAGES];
   logic [PW-1:0]     prod_r [STAGES];
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [OCC_W-1:0]  occ_r;

   logic [STAGES-1:0] load_s;
   logic [STAGES-1:0] adv_s;
   logic [STAGES-1:0] nxt_v_s;
   logic [STAGES-1:0] nxt_wr_s;
   logic [ROB_W-1:0]  nxt_rob_s  [STAGES];
   logic [PC_W-1:0]   nxt_pc_s   [STAGES];
   logic [REG_W-1:0]  nxt_dst_s  [STAGES];
   logic [PW-1:0]     nxt_prod_s [STAGES];
   logic [PW-1:0]     prod_s;
   logic              accept_s;
   logic              retire_s;

`ifdef MUL_PIPE_SIGNED_EN
   logic sgn_r;
   assign prod_s = mul_ext(a_r, b_r, sgn_r);
`else
   logic unused_signed;
   assign unused_signed = in_signed;
   assign prod_s = mul_ext(a_r, b_r, 1'b0);
`endif

   // Ready chain: resolved from the output back toward the input so gaps collapse.
   always_comb begin
      load_s = '0;
      adv_s  = '0;
      adv_s[STAGES-1]  = v_r[STAGES-1] & out_ready;
      load_s[STAGES-1] = ~v_r[STAGES-1] | adv_s[STAGES-1];
      for (int s = STAGES-2; s >= 0; s--) begin
         adv_s[s]  = v_r[s] & load_s[s+1];
         load_s[s] = ~v_r[s] | adv_s[s];
      end
   end

   // Source of each stage's next contents: the input for stage 0, the previous stage otherwise.
   always_comb begin
      nxt_v_s       = '0;
      nxt_wr_s      = '0;
      nxt_v_s[0]    = in_valid;
      nxt_wr_s[0]   = in_wr;
      nxt_rob_s[0]  = in_rob;
      nxt_pc_s[0]   = in_pc;
      nxt_dst_s[0]  = in_dst;
      nxt_prod_s[0] = prod_s;
      for (int s = 1; s < STAGES; s++) begin
         nxt_v_s[s]    = v_r[s-1];
         nxt_wr_s[s]   = wr_r[s-1];
         nxt_rob_s[s]  = rob_r[s-1];
         nxt_pc_s[s]   = pc_r[s-1];
         nxt_dst_s[s]  = dst_r[s-1];
         nxt_prod_s[s] = (s == 1) ? prod_s : prod_r[s-1];
      end
   end

   assign in_ready = load_s[0];
   assign accept_s = in_valid & in_ready;
   assign retire_s = v_r[STAGES-1] & out_ready;

   // Valid bits: reset and clear drop every in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_r <= '0;
      end else if (clear) begin
         v_r <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (load_s[s]) begin
               v_r[s] <= nxt_v_s[s];
            end
         end
      end
   end

   // Payload registers: never reset, loaded whenever the stage loads.
   always_ff @(posedge clk) begin
      if (load_s[0]) begin
         a_r <= in_a;
         b_r <= in_b;
`ifdef MUL_PIPE_SIGNED_EN
         sgn_r <= in_signed;
`endif
      end
      for (int s = 0; s < STAGES; s++) begin
         if (load_s[s]) begin
            wr_r[s]  <= nxt_wr_s[s];
            rob_r[s] <= nxt_rob_s[s];
            pc_r[s]  <= nxt_pc_s[s];
            dst_r[s] <= nxt_dst_s[s];
            if (s > 0) begin
               prod_r[s] <= nxt_prod_s[s];
            end
         end
      end
   end

   // Occupancy counter tracks accepts minus retires.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r <= '0;
      end else if (clear) begin
         occ_r <= '0;
      end else begin
         case ({accept_s, retire_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1);
            2'b01:   occ_r <= occ_r - OCC_W'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Hazard slots: slot 0 is the input port, slot j is stage j-1.
   always_comb begin
      haz_valid            = '0;
      haz_dst              = '0;
      haz_valid[0]         = in_valid & in_wr;
      haz_dst[0 +: REG_W]  = in_dst;
      for (int j = 1; j <= STAGES; j++) begin
         haz_valid[j]             = v_r[j-1] & wr_r[j-1];
         haz_dst[j*REG_W +: REG_W] = dst_r[j-1];
      end
   end

   assign out_valid = v_r[STAGES-1];
   assign out_rob   = rob_r[STAGES-1];
   assign out_pc    = pc_r[STAGES-1];
   assign out_dst   = dst_r[STAGES-1];
   assign out_wr    = wr_r[STAGES-1];
   assign occ       = occ_r;

   generate
      if (STAGES == 1) begin : g_comb_prod
         assign {out_hi, out_lo} = prod_s;
      end else begin : g_reg_prod
         assign {out_hi, out_lo} = prod_r[STAGES-1];
      end
   endgenerate
endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: scoreboard of expected results plus
// per-scenario tasks for latency, operand extremes, streaming, stalls, bubbles and clear.
module tb_mul_pipe;
   localparam int DW = 32;
   localparam int ST = 4;
   localparam int RW = 4;
   localparam int GW = 5;
   localparam int PW = 32;
   localparam int OW = $clog2(ST+1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_signed = 1'b0;
   logic [RW-1:0]     in_rob = '0;
   logic [PW-1:0]     in_pc = '0;
   logic [GW-1:0]     in_dst = '0;
   logic              in_wr = 1'b0;
   logic [DW-1:0]     in_a = '0;
   logic [DW-1:0]     in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [RW-1:0]     out_rob;
   logic [PW-1:0]     out_pc;
   logic [GW-1:0]     out_dst;
   logic              out_wr;
   logic [DW-1:0]     out_hi;
   logic [DW-1:0]     out_lo;
   logic [ST:0]       haz_valid;
   logic [(ST+1)*GW-1:0] haz_dst;
   logic [OW-1:0]     occ;

   mul_pipe #(.DATA_W(DW), .STAGES(ST), .ROB_W(RW), .REG_W(GW), .PC_W(PW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .in_rob(in_rob), .in_pc(in_pc), .in_dst(in_dst), .in_wr(in_wr),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_rob(out_rob), .out_pc(out_pc), .out_dst(out_dst), .out_wr(out_wr),
      .out_hi(out_hi), .out_lo(out_lo), .haz_valid(haz_valid), .haz_dst(haz_dst), .occ(occ)
   );

   typedef struct packed {
      logic [RW-1:0]   rob;
      logic [PW-1:0]   pc;
      logic [GW-1:0]   dst;
      logic            wr;
      logic [2*DW-1:0] prod;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ret_cnt = 0;
   int   ret_gaps = 0;
   int   last_ret = 0;
   int   occ_max = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Scoreboard monitor: occupancy tracking, push on accept, pop and compare on retire.
   always @(negedge clk) begin
      exp_t e;
      logic sg;
      if (!rst) begin
         n_checks++;
         if (occ !== OW'(sb.size())) begin
            n_fail++;
            $display("FAIL occ_track: occ=%0d expected %0d at cycle %0d", occ, sb.size(), cyc);
         end
         if (int'(occ) > occ_max) occ_max = int'(occ);
         if (!clear) begin
            if (out_valid && out_ready) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_out: rob=%0h with empty scoreboard", out_rob);
               end else begin
                  e = sb.pop_front();
                  if ({out_rob, out_pc, out_dst, out_wr, out_hi, out_lo} !== e) begin
                     n_fail++;
                     $display("FAIL result: got rob=%0h pc=%0h dst=%0d wr=%0b prod=%h expected rob=%0h pc=%0h dst=%0d wr=%0b prod=%h",
                              out_rob, out_pc, out_dst, out_wr, {out_hi, out_lo},
                              e.rob, e.pc, e.dst, e.wr, e.prod);
                  end
                  if (ret_cnt > 0 && cyc != last_ret + 1) ret_gaps++;
                  last_ret = cyc;
                  ret_cnt++;
               end
            end
            if (in_valid && in_ready) begin
               sg = 1'b0;
`ifdef MUL_PIPE_SIGNED_EN
               sg = in_signed;
`endif
               e.rob = in_rob;
               e.pc  = in_pc;
               e.dst = in_dst;
               e.wr  = in_wr;
               if (sg) e.prod = 64'($signed(in_a)) * 64'($signed(in_b));
               else    e.prod = 64'(in_a) * 64'(in_b);
               sb.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sg,
                        input logic [RW-1:0] rob, input logic [PW-1:0] pc,
                        input logic [GW-1:0] dst, input logic wr);
      bit got = 1'b0;
      in_a = a; in_b = b; in_signed = sg; in_rob = rob; in_pc = pc; in_dst = dst; in_wr = wr;
      in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL drive_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int t = 0; t < 200; t++) begin
         step();
         if (sb.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d entries still expected", sb.size());
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_wr = 1'b1; in_dst = 5'd3;
      step(); step();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
      n_checks++; if (occ !== OW'(0)) begin n_fail++; $display("FAIL rst_occ: %0d required 0", occ); end
      n_checks++; if (haz_valid[ST:1] !== '0) begin n_fail++; $display("FAIL rst_haz: %b required 0", haz_valid[ST:1]); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: %b required 1", in_ready); end
      n_checks++; if (haz_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rst_haz0: %b required 1", haz_valid[0]); end
      n_checks++; if (haz_dst[GW-1:0] !== 5'd3) begin n_fail++; $display("FAIL rst_haz_dst0: %0d required 3", haz_dst[GW-1:0]); end
      step();
      rst = 1'b0; in_valid = 1'b0; in_wr = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      drive(32'd7, 32'd6, 1'b0, 4'h5, 32'h0000_1000, 5'd9, 1'b1);
      wait_out(lat);
      n_checks++; if (lat != ST) begin n_fail++; $display("FAIL latency: %0d negedges required %0d", lat, ST); end
      n_checks++; if (out_lo !== 32'd42 || out_hi !== 32'd0) begin n_fail++; $display("FAIL basic_prod: %h_%h required 0_2a", out_hi, out_lo); end
      n_checks++;
      if (out_rob !== 4'h5 || out_pc !== 32'h0000_1000 || out_dst !== 5'd9) begin
         n_fail++; $display("FAIL basic_meta: rob=%0h pc=%0h dst=%0d required 5 1000 9", out_rob, out_pc, out_dst);
      end
      wait_drain();
   endtask

   task automatic test_unsigned_max();
      int lat;
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1, 32'h2000, 5'd1, 1'b1);
      wait_out(lat);
      n_checks++;
      if (out_hi !== 32'hFFFF_FFFE || out_lo !== 32'h0000_0001) begin
         n_fail++; $display("FAIL umax: %h_%h required fffffffe_00000001", out_hi, out_lo);
      end
      wait_drain();
   endtask

   task automatic test_signed();
`ifdef MUL_PIPE_SIGNED_EN
      int lat;
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2, 32'h3000, 5'd2, 1'b1);
      wait_out(lat);
      n_checks++;
      if ({out_hi, out_lo} !== 64'h0000_0000_0000_0001) begin
         n_fail++; $display("FAIL smin1: %h_%h required 0_1", out_hi, out_lo);
      end
      wait_drain();
      drive(32'hFFFF_FFFD, 32'd5, 1'b1, 4'h3, 32'h3004, 5'd3, 1'b1);
      wait_out(lat);
      n_checks++;
      if ({out_hi, out_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         n_fail++; $display("FAIL sneg: %h_%h required ffffffff_fffffff1", out_hi, out_lo);
      end
      wait_drain();
`else
      int lat;
      drive(32'hFFFF_FFFD, 32'd5, 1'b1, 4'h3, 32'h3004, 5'd3, 1'b1);
      wait_out(lat);
      n_checks++;
      if ({out_hi, out_lo} !== 64'h0000_0004_FFFF_FFF1) begin
         n_fail++; $display("FAIL signed_ignored: %h_%h required 00000004_fffffff1", out_hi, out_lo);
      end
      wait_drain();
`endif
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      ret_cnt = 0; ret_gaps = 0; occ_max = 0;
      for (int i = 0; i < 10; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)), RW'(i), $urandom, GW'(i + 4), 1'b1);
      end
      wait_drain();
      n_checks++; if (ret_cnt != 10) begin n_fail++; $display("FAIL b2b_count: %0d required 10", ret_cnt); end
      n_checks++; if (ret_gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: %0d required 0", ret_gaps); end
      n_checks++; if (occ_max > ST) begin n_fail++; $display("FAIL b2b_occ: max %0d required <= %0d", occ_max, ST); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] lo_hold;
      logic [RW-1:0] rob_hold;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive($urandom, $urandom, 1'b0, RW'(i), 32'h4000 + 32'(i), GW'(i), 1'b1);
      end
      in_a = 32'd11; in_b = 32'd13; in_rob = 4'd4; in_pc = 32'h4004; in_dst = 5'd4; in_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: %b required 0", in_ready); end
      n_checks++; if (occ !== OW'(ST)) begin n_fail++; $display("FAIL bp_occ: %0d required %0d", occ, ST); end
      lo_hold = out_lo; rob_hold = out_rob;
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_lo !== lo_hold || out_rob !== rob_hold || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b lo=%h rob=%0h in_ready=%b required 1 %h %0h 0",
                     out_valid, out_lo, out_rob, in_ready, lo_hold, rob_hold);
         end
      end
      n_checks++; if (rob_hold !== 4'd0) begin n_fail++; $display("FAIL bp_head: rob=%0h required 0", rob_hold); end
      step();
      out_ready = 1'b1;
      drive(32'd11, 32'd13, 1'b0, 4'd4, 32'h4004, 5'd4, 1'b1);
      drive(32'd17, 32'd19, 1'b0, 4'd5, 32'h4005, 5'd5, 1'b1);
      wait_drain();
   endtask

   task automatic test_bubbles();
      logic [ST:0] hv_tab [3];
      int pa_tab [3];
      int pb_tab [3];
      hv_tab[0] = 5'b01010; pa_tab[0] = 3; pb_tab[0] = 1;
      hv_tab[1] = 5'b10100; pa_tab[1] = 4; pb_tab[1] = 2;
      hv_tab[2] = 5'b11000; pa_tab[2] = 4; pb_tab[2] = 3;
      out_ready = 1'b0;
      drive(32'd3, 32'd4, 1'b0, 4'hA, 32'h5000, 5'd10, 1'b1);
      step();
      drive(32'd5, 32'd6, 1'b0, 4'hB, 32'h5004, 5'd11, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (haz_valid !== hv_tab[i] || haz_dst[pa_tab[i]*GW +: GW] !== 5'd10 ||
             haz_dst[pb_tab[i]*GW +: GW] !== 5'd11) begin
            n_fail++;
            $display("FAIL bubble_haz[%0d]: valid=%b dstA=%0d dstB=%0d required %b 10 11", i, haz_valid,
                     haz_dst[pa_tab[i]*GW +: GW], haz_dst[pb_tab[i]*GW +: GW], hv_tab[i]);
         end
      end
      step();
      out_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_clear();
      int seen = 0;
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive($urandom, $urandom, 1'b0, RW'(i), 32'h6000 + 32'(i), GW'(i + 20), 1'b1);
      end
      step();
      clear = 1'b1; out_ready = 1'b1;
      in_a = 32'd2; in_b = 32'd2; in_rob = 4'd7; in_dst = 5'd7; in_wr = 1'b1; in_valid = 1'b1;
      step();
      clear = 1'b0; in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      n_checks++; if (occ !== OW'(0)) begin n_fail++; $display("FAIL clr_occ: %0d required 0", occ); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: %b required 0", out_valid); end
      n_checks++; if (haz_valid[ST:1] !== '0) begin n_fail++; $display("FAIL clr_haz: %b required 0", haz_valid[ST:1]); end
      for (int k = 0; k < 8; k++) begin
         step();
         if (out_valid) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL clr_leak: %0d outputs required 0", seen); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_unsigned_max();
      test_signed();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
